// File: rtl/gb_cpu_common_pkg.sv
// Shared GameBoy CPU types: register file names, ALU/IDU opcodes, the per-M-cycle
// control word handed from decoder to scheduler, and scheduler state/constants.
package gb_cpu_common_pkg;

    typedef enum logic [2:0] {
        REG_B, REG_C, REG_D, REG_E, REG_H, REG_L, REG_A, REG_F
    } reg8_t;

    typedef enum logic [2:0] {
        REG_BC, REG_DE, REG_HL, REG_SP, REG_PC, REG_WZ
    } reg16_t;

    typedef enum logic [3:0] {
        ALU_NOP, ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC, ALU_AND,
        ALU_XOR, ALU_OR,  ALU_CP,  ALU_INC, ALU_DEC
    } alu_opcode_t;

    typedef enum logic [1:0] {
        IDU_NOP, IDU_INC, IDU_DEC
    } idu_opcode_t;

    typedef enum logic [1:0] {
        ADDR_BUS_REG16, ADDR_BUS_HIGH_C, ADDR_BUS_HIGH_Z, ADDR_BUS_WZ
    } addr_bus_source_t;

    typedef struct packed {
        alu_opcode_t      alu_opcode;
        logic             alu_wren;
        reg8_t            alu_dst;
        idu_opcode_t      idu_opcode;
        logic             idu_wren;
        reg16_t           idu_reg;
        addr_bus_source_t addr_bus_source;
        reg16_t           addr_reg16;
        logic             bus_read;
        logic             bus_write;
        logic             cc_check;
        logic             enable_interrupts;
        logic             disable_interrupts;
    } control_signals_t;

    // Idle control word: nothing written, address bus parked on PC.
    localparam control_signals_t CTRL_NOP = '{
        alu_opcode:         ALU_NOP,
        alu_wren:           1'b0,
        alu_dst:            REG_B,
        idu_opcode:         IDU_NOP,
        idu_wren:           1'b0,
        idu_reg:            REG_BC,
        addr_bus_source:    ADDR_BUS_REG16,
        addr_reg16:         REG_PC,
        bus_read:           1'b0,
        bus_write:          1'b0,
        cc_check:           1'b0,
        enable_interrupts:  1'b0,
        disable_interrupts: 1'b0
    };

    typedef enum logic {
        SCHED_IDLE,
        SCHED_RUN
    } sched_state_t;

    localparam int SCHED_DEPTH = 6;

endpackage

// File: rtl/gb_cpu_ime_ctrl.sv
// Interrupt master enable flag. With GB_SCHED_EI_DELAY_EN defined, EI arms a pending
// flag that sets IME at the final commit of the following instruction.
module gb_cpu_ime_ctrl (
    input  logic clk,
    input  logic rst_n,
    input  logic i_commit,
    input  logic i_ei,
    input  logic i_di,
    input  logic i_final,
    output logic o_ime
);

    logic r_ime;

`ifdef GB_SCHED_EI_DELAY_EN
    logic r_ei_pending;
    logic r_ei_armed;

    // Armed means the EI's own instruction has ended; the next final commit applies it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ime        <= 1'b0;
            r_ei_pending <= 1'b0;
            r_ei_armed   <= 1'b0;
        end else if (i_commit) begin
            if (i_di) begin
                r_ime        <= 1'b0;
                r_ei_pending <= 1'b0;
                r_ei_armed   <= 1'b0;
            end else if (i_ei) begin
                r_ei_pending <= 1'b1;
                r_ei_armed   <= i_final;
            end else if (i_final && r_ei_pending) begin
                if (r_ei_armed) begin
                    r_ime        <= 1'b1;
                    r_ei_pending <= 1'b0;
                    r_ei_armed   <= 1'b0;
                end else begin
                    r_ei_armed   <= 1'b1;
                end
            end
        end
    end
`else
    logic w_unused_final;
    assign w_unused_final = i_final;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ime <= 1'b0;
        end else if (i_commit) begin
            if (i_di) begin
                r_ime <= 1'b0;
            end else if (i_ei) begin
                r_ime <= 1'b1;
            end
        end
    end
`endif

    assign o_ime = r_ime;

endmodule

// File: rtl/gb_cpu_mcycle_scheduler.sv
// Per-instruction M-cycle sequencer: steps decoder-supplied control words through T-cycles,
// truncates on failed condition checks and owns IME (EI delay under GB_SCHED_EI_DELAY_EN).
module gb_cpu_mcycle_scheduler
    import gb_cpu_common_pkg::*;
#(
    parameter int DEPTH = SCHED_DEPTH,
    parameter int TICKS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load_i,
    input  logic [2:0]                   load_len_i,
    input  control_signals_t [DEPTH-1:0] load_sched_i,
    input  logic                         stall_i,
    input  logic                         cc_met_i,
    output control_signals_t             ctrl_o,
    output logic [1:0]                   tcycle_o,
    output logic [2:0]                   slot_o,
    output logic                         mcycle_end_o,
    output logic                         final_o,
    output logic                         busy_o,
    output logic                         ime_o
);

    localparam logic [1:0] LAST_TICK = 2'(TICKS - 1);
    localparam logic [2:0] DEPTH_LEN = 3'(DEPTH);

    sched_state_t                 r_state;
    control_signals_t [DEPTH-1:0] r_sched;
    logic [2:0]                   r_len;
    logic [2:0]                   r_slot;
    logic [1:0]                   r_tcycle;

    logic             w_running;
    control_signals_t w_cur;
    logic             w_cc_fail;
    logic             w_last_slot;
    logic             w_final;
    logic             w_mcycle_end;
    logic [2:0]       w_len_clamped;
    logic             w_accept;

    assign w_running     = (r_state == SCHED_RUN);
    assign w_cur         = r_sched[r_slot];
    assign w_cc_fail     = w_cur.cc_check & ~cc_met_i;
    assign w_last_slot   = (r_slot == r_len - 3'd1);
    assign w_final       = w_running & (w_last_slot | w_cc_fail);
    assign w_mcycle_end  = w_running & (r_tcycle == LAST_TICK) & ~stall_i;
    assign w_len_clamped = (load_len_i > DEPTH_LEN) ? DEPTH_LEN : load_len_i;
    // A new schedule may overlap only the commit edge of the current final slot.
    assign w_accept      = load_i & (load_len_i != 3'd0) & (~w_running | (w_final & w_mcycle_end));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= SCHED_IDLE;
            r_sched  <= {DEPTH{CTRL_NOP}};
            r_len    <= 3'd0;
            r_slot   <= 3'd0;
            r_tcycle <= 2'd0;
        end else if (w_accept) begin
            r_state  <= SCHED_RUN;
            r_sched  <= load_sched_i;
            r_len    <= w_len_clamped;
            r_slot   <= 3'd0;
            r_tcycle <= 2'd0;
        end else if (w_running && !stall_i) begin
            if (r_tcycle == LAST_TICK) begin
                r_tcycle <= 2'd0;
                if (w_final) begin
                    r_state <= SCHED_IDLE;
                    r_slot  <= 3'd0;
                end else begin
                    r_slot  <= r_slot + 3'd1;
                end
            end else begin
                r_tcycle <= r_tcycle + 2'd1;
            end
        end
    end

    gb_cpu_ime_ctrl u_ime_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_commit (w_mcycle_end),
        .i_ei     (w_cur.enable_interrupts),
        .i_di     (w_cur.disable_interrupts),
        .i_final  (w_final),
        .o_ime    (ime_o)
    );

    assign ctrl_o       = w_running ? w_cur : CTRL_NOP;
    assign tcycle_o     = r_tcycle;
    assign slot_o       = r_slot;
    assign mcycle_end_o = w_mcycle_end;
    assign final_o      = w_final;
    assign busy_o       = w_running;

endmodule

// File: tb/tb_gb_cpu_mcycle_scheduler.sv
// Self-checking bench for gb_cpu_mcycle_scheduler: directed scenarios with literal
// expectations plus randomized traffic against an elapsed-cycle reference model.
module tb_gb_cpu_mcycle_scheduler;
    import gb_cpu_common_pkg::*;

    localparam int DEPTH = 6;
    localparam int TICKS = 4;

    typedef control_signals_t [DEPTH-1:0] sched_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             load_i = 1'b0;
    logic [2:0]       load_len_i = 3'd0;
    sched_t           load_sched_i = {DEPTH{CTRL_NOP}};
    logic             stall_i = 1'b0;
    logic             cc_met_i = 1'b1;
    control_signals_t ctrl_o;
    logic [1:0]       tcycle_o;
    logic [2:0]       slot_o;
    logic             mcycle_end_o;
    logic             final_o;
    logic             busy_o;
    logic             ime_o;

    int checks   = 0;
    int failures = 0;
    bit done     = 1'b0;

    always #5 clk = ~clk;

    gb_cpu_mcycle_scheduler #(
        .DEPTH (DEPTH),
        .TICKS (TICKS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (load_i),
        .load_len_i   (load_len_i),
        .load_sched_i (load_sched_i),
        .stall_i      (stall_i),
        .cc_met_i     (cc_met_i),
        .ctrl_o       (ctrl_o),
        .tcycle_o     (tcycle_o),
        .slot_o       (slot_o),
        .mcycle_end_o (mcycle_end_o),
        .final_o      (final_o),
        .busy_o       (busy_o),
        .ime_o        (ime_o)
    );

    // Reference model: an instruction is a list of control words plus a count of
    // un-stalled cycles spent in it; slot and tick follow by division.
    bit               m_active;
    int               m_elapsed;
    int               m_len;
    control_signals_t m_sched [DEPTH];
    bit               m_ime;
    int               m_ei_wait;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic modelReset();
        m_active  = 1'b0;
        m_elapsed = 0;
        m_len     = 0;
        m_ime     = 1'b0;
        m_ei_wait = 0;
        for (int s = 0; s < DEPTH; s++) m_sched[s] = CTRL_NOP;
    endtask

    task automatic modelOutputs(output control_signals_t e_ctrl, output bit e_mend,
                                output bit e_fin, output int e_slot, output int e_tick);
        e_slot = m_active ? m_elapsed / TICKS : 0;
        e_tick = m_active ? m_elapsed % TICKS : 0;
        e_ctrl = m_active ? m_sched[e_slot] : CTRL_NOP;
        e_mend = m_active && (e_tick == TICKS - 1) && !stall_i;
        e_fin  = m_active && ((e_slot == m_len - 1) || (e_ctrl.cc_check && !cc_met_i));
    endtask

    task automatic imeCommit(input control_signals_t c, input bit fin);
`ifdef GB_SCHED_EI_DELAY_EN
        if (c.disable_interrupts) begin
            m_ime     = 1'b0;
            m_ei_wait = 0;
        end else if (c.enable_interrupts) begin
            m_ei_wait = fin ? 1 : 2;
        end else if (fin && m_ei_wait > 0) begin
            m_ei_wait--;
            if (m_ei_wait == 0) m_ime = 1'b1;
        end
`else
        if (c.disable_interrupts) m_ime = 1'b0;
        else if (c.enable_interrupts) m_ime = 1'b1;
`endif
    endtask

    task automatic modelStep();
        control_signals_t e_ctrl;
        bit               e_mend;
        bit               e_fin;
        int               e_slot;
        int               e_tick;
        bit               accept;
        if (!rst_n) begin
            modelReset();
            return;
        end
        modelOutputs(e_ctrl, e_mend, e_fin, e_slot, e_tick);
        accept = load_i && (load_len_i != 3'd0) && (!m_active || (e_fin && e_mend));
        if (e_mend) begin
            imeCommit(e_ctrl, e_fin);
            if (e_fin) begin
                m_active  = 1'b0;
                m_elapsed = 0;
            end else begin
                m_elapsed++;
            end
        end else if (m_active && !stall_i) begin
            m_elapsed++;
        end
        if (accept) begin
            m_active  = 1'b1;
            m_elapsed = 0;
            m_len     = (int'(load_len_i) > DEPTH) ? DEPTH : int'(load_len_i);
            for (int s = 0; s < DEPTH; s++) m_sched[s] = load_sched_i[s];
        end
    endtask

    task automatic checkOutput();
        control_signals_t e_ctrl;
        bit               e_mend;
        bit               e_fin;
        int               e_slot;
        int               e_tick;
        modelOutputs(e_ctrl, e_mend, e_fin, e_slot, e_tick);
        chk("ctrl_o",       32'(ctrl_o),       32'(e_ctrl));
        chk("tcycle_o",     32'(tcycle_o),     32'(e_tick));
        chk("slot_o",       32'(slot_o),       32'(e_slot));
        chk("mcycle_end_o", 32'(mcycle_end_o), 32'(e_mend));
        chk("final_o",      32'(final_o),      32'(e_fin));
        chk("busy_o",       32'(busy_o),       32'(m_active));
        chk("ime_o",        32'(ime_o),        32'(m_ime));
    endtask

    // Compare process: outputs checked mid-cycle, model advanced on the active edge.
    initial begin
        modelReset();
        while (!done) begin
            @(negedge clk);
            #2;
            if (!rst_n) modelReset();
            checkOutput();
            @(posedge clk);
            modelStep();
        end
    end

    initial begin
        #1000000;
        failures++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic ld, input logic [2:0] len, input sched_t s,
                                 input logic st, input logic cc);
        load_i       = ld;
        load_len_i   = len;
        load_sched_i = s;
        stall_i      = st;
        cc_met_i     = cc;
    endtask

    task automatic startLoad(input logic [2:0] len, input sched_t s);
        applyStimulus(1'b1, len, s, 1'b0, cc_met_i);
        cyc();
        load_i = 1'b0;
    endtask

    task automatic waitIdle(input int bound);
        int n;
        n = 0;
        while (busy_o && n < bound) begin
            cyc();
            n++;
        end
        chk("wait_idle_bound", 32'(busy_o), 32'd0);
    endtask

    function automatic control_signals_t mk(input alu_opcode_t op);
        control_signals_t c;
        c            = CTRL_NOP;
        c.alu_opcode = op;
        return c;
    endfunction

    function automatic control_signals_t rndCtrl();
        logic [31:0]      r;
        control_signals_t c;
        r                    = $urandom();
        c                    = control_signals_t'(r[$bits(control_signals_t)-1:0]);
        c.cc_check           = ($urandom_range(0, 3) == 0);
        c.enable_interrupts  = ($urandom_range(0, 5) == 0);
        c.disable_interrupts = ($urandom_range(0, 7) == 0);
        return c;
    endfunction

    initial begin
        sched_t      sA;
        sched_t      sB;
        sched_t      sNop;
        sched_t      sEi;
        sched_t      sDi;
        alu_opcode_t expOp;

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        sNop = {DEPTH{CTRL_NOP}};
        sEi  = sNop;
        sEi[0].enable_interrupts = 1'b1;
        sDi  = sNop;
        sDi[0].disable_interrupts = 1'b1;

        // Reset state
        cyc();
        cyc();
        #1;
        chk("rst_ctrl",   32'(ctrl_o),       32'(CTRL_NOP));
        chk("rst_busy",   32'(busy_o),       32'd0);
        chk("rst_ime",    32'(ime_o),        32'd0);
        chk("rst_slot",   32'(slot_o),       32'd0);
        chk("rst_tcycle", 32'(tcycle_o),     32'd0);
        chk("rst_mend",   32'(mcycle_end_o), 32'd0);
        chk("rst_final",  32'(final_o),      32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Three-slot ADD/INC/XOR schedule
        $display("[TB] len=3 ADD/INC/XOR schedule");
        sA = sNop;
        sA[0] = mk(ALU_ADD);
        sA[1] = mk(ALU_INC);
        sA[2] = mk(ALU_XOR);
        startLoad(3'd3, sA);
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) cyc();
            #1;
            expOp = (c < 4) ? ALU_ADD : (c < 8) ? ALU_INC : (c < 12) ? ALU_XOR : ALU_NOP;
            chk("t1_alu_op", 32'(ctrl_o.alu_opcode), 32'(expOp));
            chk("t1_mend",   32'(mcycle_end_o),      32'((c % 4 == 3) && (c < 12)));
            chk("t1_busy",   32'(busy_o),            32'(c < 12));
        end
        chk("t1_idle_ctrl", 32'(ctrl_o), 32'(CTRL_NOP));

        // Condition check fails in slot 1, then passes
        $display("[TB] cc_check truncation");
        cyc();
        sA = sNop;
        sA[1].cc_check = 1'b1;
        cc_met_i = 1'b0;
        startLoad(3'd5, sA);
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) cyc();
            #1;
            chk("t2_final", 32'(final_o), 32'((c >= 4) && (c < 8)));
            chk("t2_busy",  32'(busy_o),  32'(c < 8));
        end
        cyc();
        cc_met_i = 1'b1;
        startLoad(3'd5, sA);
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) cyc();
            #1;
            chk("t2b_busy",  32'(busy_o),  32'(c < 20));
            chk("t2b_slot",  32'(slot_o),  32'((c < 20) ? c / 4 : 0));
            chk("t2b_final", 32'(final_o), 32'((c >= 16) && (c < 20)));
        end

        // Length above DEPTH is clamped
        cyc();
        startLoad(3'd7, {DEPTH{mk(ALU_ADD)}});
        for (int c = 1; c <= 23; c++) cyc();
        #1;
        chk("clamp_last_slot", 32'(slot_o), 32'd5);
        chk("clamp_busy_end",  32'(busy_o), 32'd1);
        cyc();
        #1;
        chk("clamp_idle",      32'(busy_o), 32'd0);

        // Back-to-back load on the final commit of a len=1 instruction
        $display("[TB] back-to-back load");
        cyc();
        sA = sNop;
        sA[0] = mk(ALU_ADD);
        sB = sNop;
        sB[0] = mk(ALU_INC);
        sB[1] = mk(ALU_XOR);
        startLoad(3'd1, sA);
        for (int c = 0; c <= 3; c++) begin
            if (c > 0) cyc();
            #1;
            chk("t3_final_len1", 32'(final_o), 32'd1);
            chk("t3_busy_len1",  32'(busy_o),  32'd1);
        end
        chk("t3_mend_last", 32'(mcycle_end_o), 32'd1);
        applyStimulus(1'b1, 3'd2, sB, 1'b0, 1'b1);
        cyc();
        load_i = 1'b0;
        #1;
        chk("t3_busy_gapless", 32'(busy_o),            32'd1);
        chk("t3_new_slot0",    32'(ctrl_o.alu_opcode), 32'(ALU_INC));
        chk("t3_new_tcycle",   32'(tcycle_o),          32'd0);
        chk("t3_new_slotidx",  32'(slot_o),            32'd0);
        for (int c = 5; c <= 12; c++) begin
            cyc();
            #1;
            expOp = (c < 8) ? ALU_INC : (c < 12) ? ALU_XOR : ALU_NOP;
            chk("t3_alu_op", 32'(ctrl_o.alu_opcode), 32'(expOp));
            chk("t3_busy",   32'(busy_o),            32'(c < 12));
        end

        // Five-cycle stall at tcycle 2 of slot 0, with an ignored mid-run load
        $display("[TB] stall and ignored load");
        cyc();
        sA = sNop;
        sA[0] = mk(ALU_ADD);
        sA[1] = mk(ALU_INC);
        startLoad(3'd2, sA);
        for (int c = 0; c <= 13; c++) begin
            if (c > 0) cyc();
            stall_i = (c >= 2) && (c <= 6);
            if (c == 4) applyStimulus(1'b1, 3'd1, {DEPTH{mk(ALU_XOR)}}, 1'b1, 1'b1);
            else load_i = 1'b0;
            #1;
            expOp = (c <= 8) ? ALU_ADD : (c < 13) ? ALU_INC : ALU_NOP;
            chk("t4_alu_op", 32'(ctrl_o.alu_opcode), 32'(expOp));
            chk("t4_tcycle", 32'(tcycle_o),
                32'((c < 2) ? c : (c <= 6) ? 2 : (c < 13) ? (c - 5) % 4 : 0));
            chk("t4_mend",   32'(mcycle_end_o),      32'((c == 8) || (c == 12)));
            chk("t4_busy",   32'(busy_o),            32'(c < 13));
        end
        stall_i = 1'b0;

        // IME: EI then a NOP instruction, then EI followed by DI
        $display("[TB] IME sequencing");
        cyc();
        startLoad(3'd1, sDi);
        waitIdle(8);
        startLoad(3'd1, sEi);
        #1;
        chk("t5_ime_before_ei", 32'(ime_o), 32'd0);
        waitIdle(8);
        #1;
`ifdef GB_SCHED_EI_DELAY_EN
        chk("t5_ime_after_ei", 32'(ime_o), 32'd0);
`else
        chk("t5_ime_after_ei", 32'(ime_o), 32'd1);
`endif
        cyc();
        startLoad(3'd1, sNop);
        waitIdle(8);
        #1;
        chk("t5_ime_after_nop", 32'(ime_o), 32'd1);
        cyc();
        startLoad(3'd1, sDi);
        waitIdle(8);
        #1;
        chk("t5_ime_after_di", 32'(ime_o), 32'd0);
        cyc();
        startLoad(3'd1, sEi);
        waitIdle(8);
        startLoad(3'd1, sDi);
        #1;
`ifdef GB_SCHED_EI_DELAY_EN
        chk("t5_ime_ei_then_di_mid", 32'(ime_o), 32'd0);
`else
        chk("t5_ime_ei_then_di_mid", 32'(ime_o), 32'd1);
`endif
        waitIdle(8);
        #1;
        chk("t5_ime_ei_then_di_end", 32'(ime_o), 32'd0);

        // Asynchronous reset at tcycle 1 of slot 2 with IME set
        $display("[TB] mid-instruction reset");
        cyc();
        startLoad(3'd1, sEi);
        waitIdle(8);
        startLoad(3'd1, sNop);
        waitIdle(8);
        #1;
        chk("t6_ime_set", 32'(ime_o), 32'd1);
        cyc();
        sA = sNop;
        sA[0] = mk(ALU_ADD);
        sA[1] = mk(ALU_INC);
        sA[2] = mk(ALU_XOR);
        sA[3] = mk(ALU_ADD);
        startLoad(3'd4, sA);
        for (int c = 1; c <= 9; c++) cyc();
        #1;
        chk("t6_pre_slot",   32'(slot_o),   32'd2);
        chk("t6_pre_tcycle", 32'(tcycle_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ctrl", 32'(ctrl_o), 32'(CTRL_NOP));
        chk("t6_rst_ime",  32'(ime_o),  32'd0);
        chk("t6_rst_busy", 32'(busy_o), 32'd0);
        cyc();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cyc();
            #1;
            chk("t6_no_resume_busy", 32'(busy_o), 32'd0);
            chk("t6_no_resume_ctrl", 32'(ctrl_o), 32'(CTRL_NOP));
        end

        // Randomized traffic checked every cycle by the compare process
        $display("[TB] random phase");
        for (int i = 0; i < 1500; i++) begin
            cyc();
            load_i     = ($urandom_range(0, 3) == 0);
            load_len_i = 3'($urandom_range(0, 7));
            for (int s = 0; s < DEPTH; s++) load_sched_i[s] = rndCtrl();
            stall_i    = load_i ? 1'b0 : ($urandom_range(0, 7) == 0);
            cc_met_i   = 1'($urandom_range(0, 1));
        end
        cyc();
        applyStimulus(1'b0, 3'd0, sNop, 1'b0, 1'b1);
        cyc();
        cyc();
        done = 1'b1;
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gb_cpu_mcycle_scheduler.md
# gb_cpu_mcycle_scheduler

Sequencer for the GameBoy CPU core's per-instruction control schedule. The decoder hands it up to `DEPTH` `control_signals_t` entries, one per M-cycle. It presents one entry per M-cycle to the datapath: regfile, ALU, IDU and bus. It counts the four T-cycles of each M-cycle, truncates the schedule when a condition-code check fails, owns the IME flag, and tells the decoder when the next opcode may be loaded.

## Interface
Parameters:
- `DEPTH`, 6: number of schedule slots (M-cycles per instruction).
- `TICKS`, 4: T-cycles per M-cycle.

Ports:
- `clk` in 1: core clock, one T-cycle per cycle.
- `rst_n` in 1: asynchronous, active-low reset.
- `load_i` in 1: decoder presents a new schedule.
- `load_len_i` in 3: valid slot count.
  - 0 means no load.
  - Values above `DEPTH` are clamped to `DEPTH`.
- `load_sched_i` in `DEPTH` x `control_signals_t`: slot 0 executes first.
- `stall_i` in 1: freezes the T-counter, slot index and IME updates (HALT/bus wait).
- `cc_met_i` in 1: condition result from the flags, sampled at the end of a slot with `cc_check`=1.
- `ctrl_o` out `control_signals_t`: active control signals. Equals `CTRL_NOP` when idle.
- `tcycle_o` out 2: T-cycle index within the current M-cycle.
- `slot_o` out 3: active slot index.
- `mcycle_end_o` out 1: commit strobe = running & `tcycle_o`==`TICKS`-1 & !`stall_i`.
- `final_o` out 1: active slot is the last one, so the decoder may fetch and load.
- `busy_o` out 1: state is RUN.
- `ime_o` out 1: interrupt master enable.

## Operation
- States:
  - IDLE: `ctrl_o`=`CTRL_NOP`, `busy_o`=0.
  - RUN: `ctrl_o`=`sched[slot]`.
- Load acceptance:
  - A load is accepted in IDLE.
  - A load is also accepted in RUN on a cycle where `final_o` & `mcycle_end_o` are both 1 (back-to-back instructions).
  - An accepted load latches all slots and `len`, sets slot=0 and tcycle=0, and enters RUN.
  - `load_i` at any other time is ignored; the running schedule is unaffected.
- Advance rules at `mcycle_end_o`:
  - If slot==len-1: go to IDLE, unless a load is accepted on the same cycle.
  - If `sched[slot].cc_check`=1 and `cc_met_i`=0: truncate the schedule and go to IDLE (or the new load). Remaining slots are discarded.
  - Otherwise: slot+1, tcycle wraps 3->0.
- `final_o` = RUN & (slot==len-1 | (`cc_check` & !`cc_met_i`)).
- Stall behaviour: while `stall_i`=1, all state holds and `ctrl_o` stays stable. `mcycle_end_o`=0.
- IME:
  - `disable_interrupts` in a committed slot clears IME and cancels any pending EI.
  - If a slot carries both `enable_interrupts` and `disable_interrupts`, DI wins.
- Datapath write enables (`alu_wren`, `idu_wren`) are only meaningful at the `mcycle_end_o` edge. The scheduler does not gate them; consumers qualify them with `mcycle_end_o`.

## Timing
- Reset values:
  - State IDLE, slot=0, tcycle=0, len=0.
  - `ctrl_o`=`CTRL_NOP`, `ime_o`=0, EI-pending=0.
  - All strobes 0.
- Load latency:
  - A load accepted at edge k shows slot 0 on `ctrl_o` from edge k, with `tcycle_o`=0.
  - Slot n is active during cycles k+4n .. k+4n+3 when there is no stall.
- Output paths:
  - `ctrl_o` and `final_o` are combinational from registered state and `cc_met_i`.
  - `mcycle_end_o` is combinational from registered state and `stall_i`.
- Reset asserted mid-instruction: all state is forced to reset values immediately. The partial schedule is lost.
- Schedule length 1: RUN lasts exactly 4 cycles, and `final_o`=1 throughout.

## Configuration
- `GB_SCHED_EI_DELAY_EN` defined:
  - EI sets EI-pending at its commit.
  - IME becomes 1 at the end of the following instruction's final M-cycle (one-instruction delay, hardware-accurate).
  - A DI before then cancels the pending EI.
- Undefined: IME is set directly at the commit of the slot carrying `enable_interrupts`. There is no pending register.

## Structure
- Package `gb_cpu_common_pkg`:
  - Move the REGISTER FILE typedefs above `control_signals_t`.
  - Add `CTRL_NOP`, a constant with all enables 0, `ALU_NOP`, `IDU_NOP`, and `addr_bus_source`=`ADDR_BUS_REG16` from `REG_PC`.
  - Add `sched_state_t {SCHED_IDLE, SCHED_RUN}`.
  - Add `SCHED_DEPTH`=6.
- Sub-module `gb_cpu_ime_ctrl` holds IME and EI-pending. Its inputs are the commit strobe, EI, DI and instruction-final.

## Test plan
- Reset, then load len=3 with `alu_opcode` ADD/INC/XOR -> `ctrl_o` sequence ADD x4, INC x4, XOR x4, then `CTRL_NOP`. `busy_o` is low at cycle 12 and `mcycle_end_o` pulses at cycles 3, 7, 11.
- Load len=5, `cc_check`=1 in slot 1, `cc_met_i`=0 -> idle after 8 cycles and `final_o`=1 in slot 1. With `cc_met_i`=1 the schedule runs the full 20 cycles.
- Load accepted at the last tick of the final slot with a second len=2 schedule -> slot 0 of the new schedule appears with no NOP gap and `busy_o` stays 1.
- `stall_i`=1 for 5 cycles at tcycle 2 of slot 0 -> `ctrl_o` and `tcycle_o` are frozen, and the instruction finishes 5 cycles late. `load_i` pulsed mid-run is ignored.
- EI slot then a len=1 NOP instruction:
  - Macro on: `ime_o` rises at the NOP's final commit.
  - Macro off: `ime_o` rises at the EI commit.
  - EI followed by DI in the next instruction (macro on): `ime_o` stays 0.
- `rst_n` low at tcycle 1 of slot 2 of a len=4 schedule -> `ctrl_o`=`CTRL_NOP`, `ime_o`=0 and `busy_o`=0 immediately. Nothing resumes after release.
